place_random_tile: RTL

Parametrised tile spawner for the 2048 game engine, the successor to the fixed 4x4 four-only placer. It takes an N×N board of W-bit tile values and places one new tile in an empty (zero) cell chosen uniformly at random. The tile is a 2 or a 4, either randomly weighted or forced by a mode input. It sits between the move/merge logic and the board register and reports when the board has no empty cell.

---
 rtl/place_random_tile.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/place_random_tile.sv
// Spawns one 2/4 tile into a uniformly chosen empty cell of an NxN 2048 board.
// Fixed-latency count/pick/place scan driven by a free-running 16-bit LFSR.
module place_random_tile #(
  parameter int          N         = 4,
  parameter int          W         = 12,
  parameter int          FOUR_PROB = 2,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 tile_sel,
  input  logic [N-1:0][N-1:0][W-1:0] board_in,
  output logic [N-1:0][N-1:0][W-1:0] board_out,
  output logic                       done,
  output logic                       full,
  output logic                       busy,
  output logic [$clog2(N)-1:0]       placed_row,
  output logic [$clog2(N)-1:0]       placed_col
);

  localparam int          RW       = $clog2(N);
  localparam int          CW       = $clog2(N*N+1);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [W-1:0] TILE2   = W'(2);
  localparam logic [W-1:0] TILE4   = W'(4);
  localparam logic [RW-1:0] LAST_IDX = RW'(N-1);

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_PICK, S_PLACE, S_FIN} state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [15:0]                 r_lfsr;
  logic                        w_fb;
  logic [N-1:0][N-1:0][W-1:0]  r_work;
  logic [N-1:0][N-1:0][W-1:0]  w_work_next;
  logic [N-1:0][N-1:0][W-1:0]  r_board_out;
  logic [1:0]                  r_sel;
  logic [RW-1:0]               r_row;
  logic [RW-1:0]               r_col;
  logic [RW-1:0]               w_row_nx;
  logic [RW-1:0]               w_col_nx;
  logic [CW-1:0]               r_cnt;
  logic [CW-1:0]               w_cnt_final;
  logic [CW-1:0]               r_target;
  logic [CW-1:0]               w_target;
  logic [W-1:0]                r_tile;
  logic [RW-1:0]               r_prow;
  logic [RW-1:0]               r_pcol;
  logic [RW-1:0]               r_row_out;
  logic [RW-1:0]               r_col_out;
  logic                        r_done;
  logic                        r_full;
  logic                        r_busy;
  logic                        w_zero;
  logic                        w_last;
  logic                        w_hit;
  logic                        w_four;

  assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_zero      = (r_work[r_row][r_col] == '0);
  assign w_last      = (r_row == LAST_IDX) && (r_col == LAST_IDX);
  assign w_cnt_final = r_cnt + {{(CW-1){1'b0}}, w_zero};
  // Scaling an 8-bit uniform value by cnt keeps the target inside 0..cnt-1.
  assign w_target    = CW'(({{CW{1'b0}}, r_lfsr[15:8]} * {8'd0, r_cnt}) >> 4'd8);
  assign w_four      = (r_sel == 2'b10) ||
                       (((r_sel == 2'b00) || (r_sel == 2'b11)) &&
                        ({1'b0, r_lfsr[3:0]} < 5'(FOUR_PROB)));

  assign board_out  = r_board_out;
  assign done       = r_done;
  assign full       = r_full;
  assign busy       = r_busy;
  assign placed_row = r_row_out;
  assign placed_col = r_col_out;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_COUNT;
        else       w_next = S_IDLE;
      end
      S_COUNT: begin
        if (!w_last)                  w_next = S_COUNT;
        else if (w_cnt_final != '0)   w_next = S_PICK;
        else                          w_next = S_FIN;
      end
      S_PICK:  w_next = S_PLACE;
      S_PLACE: begin
        if (w_last) w_next = S_FIN;
        else        w_next = S_PLACE;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Working-board update, write strobe and row-major scan stepping
  always_comb begin
    w_work_next = r_work;
    w_hit       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_work_next = board_in;
        else       w_work_next = r_work;
      end
      S_PLACE: begin
        if (w_zero && (r_cnt == r_target)) begin
          w_hit                     = 1'b1;
          w_work_next[r_row][r_col] = r_tile;
        end else begin
          w_hit = 1'b0;
        end
      end
      default: w_hit = 1'b0;
    endcase
    if (w_last) begin
      w_row_nx = '0;
      w_col_nx = '0;
    end else if (r_col == LAST_IDX) begin
      w_row_nx = r_row + 1'b1;
      w_col_nx = '0;
    end else begin
      w_row_nx = r_row;
      w_col_nx = r_col + 1'b1;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr      <= SEED_EFF;
      r_work      <= '0;
      r_board_out <= '0;
      r_sel       <= 2'b00;
      r_row       <= '0;
      r_col       <= '0;
      r_cnt       <= '0;
      r_target    <= '0;
      r_tile      <= '0;
      r_prow      <= '0;
      r_pcol      <= '0;
      r_row_out   <= '0;
      r_col_out   <= '0;
      r_done      <= 1'b0;
      r_full      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
      r_work <= w_work_next;
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_FIN);
      // Results land on entry to FIN, so the last-cell write is taken from w_work_next.
      if (w_next == S_FIN) begin
        r_board_out <= w_work_next;
        r_full      <= (r_state == S_COUNT);
        r_row_out   <= w_hit ? r_row : r_prow;
        r_col_out   <= w_hit ? r_col : r_pcol;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sel  <= tile_sel;
            r_cnt  <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_prow <= '0;
            r_pcol <= '0;
          end
        end
        S_COUNT: begin
          r_cnt <= w_cnt_final;
          r_row <= w_row_nx;
          r_col <= w_col_nx;
        end
        S_PICK: begin
          r_target <= w_target;
          r_tile   <= w_four ? TILE4 : TILE2;
          r_cnt    <= '0;
          r_row    <= '0;
          r_col    <= '0;
        end
        S_PLACE: begin
          if (w_zero) r_cnt <= r_cnt + CW'(1);
          if (w_hit) begin
            r_prow <= r_row;
            r_pcol <= r_col;
          end
          r_row <= w_row_nx;
          r_col <= w_col_nx;
        end
        default: ;
      endcase
    end
  end

endmodule
